// File: rtl/cache_ctrl.sv
// cache_ctrl: request controller in front of the single-entry cacheline store.
// Accepts CPU read/write requests, probes the line, fetches from memory on a
// read miss, writes through to memory on writes, refills the line and returns
// a response. Keeps saturating hit/miss counters and a memory-timeout watchdog.
//
// Ports:
//   clock, reset_n                 clock, async active-low reset
//   req_valid/ready/write/addr/wdata   CPU request channel
//   resp_valid/ready/data/hit/err      CPU response channel
//   line_addr/val/read/write       strobes and data to the cacheline
//   line_hit, line_out_val         cacheline probe result (cycle after line_read)
//   mem_req/we/addr/wdata          backing-memory request, held until mem_ack
//   mem_ack, mem_rdata             backing-memory completion
//   hit_count, miss_count          saturating read hit/miss counters
module cache_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic [7:0]       req_addr,
  input  logic [31:0]      req_wdata,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [31:0]      resp_data,
  output logic             resp_hit,
  output logic             resp_err,
  output logic [7:0]       line_addr,
  output logic [31:0]      line_val,
  output logic             line_read,
  output logic             line_write,
  input  logic             line_hit,
  input  logic [31:0]      line_out_val,
  output logic             mem_req,
  output logic             mem_we,
  output logic [7:0]       mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic             mem_ack,
  input  logic [31:0]      mem_rdata,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count
);

  localparam int unsigned WD_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam bit WD_EN = (MEM_TIMEOUT != 0);
  localparam logic [WD_W-1:0] WD_LAST = WD_EN ? WD_W'(MEM_TIMEOUT - 1) : '0;

  typedef enum logic [2:0] {
    IDLE, LOOKUP, CHECK, MEM_RD, MEM_WR, FILL, RESP
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic             write_q, write_d;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;
  logic [7:0]       line_addr_q, line_addr_d;
  logic [31:0]      line_val_q, line_val_d;
  logic             line_read_q, line_read_d;
  logic             line_write_q, line_write_d;
  logic             mem_req_q, mem_req_d;
  logic             mem_we_q, mem_we_d;
  logic [7:0]       mem_addr_q, mem_addr_d;
  logic [31:0]      mem_wdata_q, mem_wdata_d;
  logic [31:0]      resp_data_q, resp_data_d;
  logic             resp_hit_q, resp_hit_d;
  logic             resp_err_q, resp_err_d;
  logic             wd_expire;

  assign wd_expire = WD_EN && (wd_q == WD_LAST);

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    write_d      = write_q;
    wd_d         = wd_q;
    hit_cnt_d    = hit_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    line_addr_d  = line_addr_q;
    line_val_d   = line_val_q;
    line_read_d  = 1'b0;
    line_write_d = 1'b0;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    resp_data_d  = resp_data_q;
    resp_hit_d   = resp_hit_q;
    resp_err_d   = resp_err_q;

    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          write_d = req_write;
          if (req_write) begin
            // Memory request is registered on the accept edge so it is
            // already visible in the first MEM_WR cycle.
            state_d     = MEM_WR;
            mem_req_d   = 1'b1;
            mem_we_d    = 1'b1;
            mem_addr_d  = req_addr;
            mem_wdata_d = req_wdata;
            wd_d        = '0;
          end else begin
            state_d     = LOOKUP;
            line_read_d = 1'b1;
            line_addr_d = req_addr;
          end
        end
      end
      LOOKUP: state_d = CHECK;
      CHECK: begin
        if (line_hit) begin
          state_d     = RESP;
          resp_data_d = line_out_val;
          resp_hit_d  = 1'b1;
          resp_err_d  = 1'b0;
          if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + 1'b1;
        end else begin
          state_d    = MEM_RD;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = addr_q;
          wd_d       = '0;
          if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + 1'b1;
        end
      end
      MEM_RD, MEM_WR: begin
        if (mem_ack) begin
          state_d      = FILL;
          line_write_d = 1'b1;
          line_addr_d  = addr_q;
          line_val_d   = (state_q == MEM_RD) ? mem_rdata : wdata_q;
        end else if (wd_expire) begin
          state_d     = RESP;
          resp_data_d = '0;
          resp_hit_d  = 1'b0;
          resp_err_d  = 1'b1;
        end else begin
          wd_d = wd_q + 1'b1;
        end
        if (mem_ack || wd_expire) begin
          mem_req_d   = 1'b0;
          mem_we_d    = 1'b0;
          mem_addr_d  = '0;
          mem_wdata_d = '0;
        end
      end
      FILL: begin
        // line_val_q still holds the fetched word for reads.
        state_d     = RESP;
        resp_data_d = write_q ? '0 : line_val_q;
        resp_hit_d  = 1'b0;
        resp_err_d  = 1'b0;
      end
      RESP: begin
        if (resp_ready) begin
          state_d     = IDLE;
          resp_data_d = '0;
          resp_hit_d  = 1'b0;
          resp_err_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      write_q      <= 1'b0;
      wd_q         <= '0;
      hit_cnt_q    <= '0;
      miss_cnt_q   <= '0;
      line_addr_q  <= '0;
      line_val_q   <= '0;
      line_read_q  <= 1'b0;
      line_write_q <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      resp_data_q  <= '0;
      resp_hit_q   <= 1'b0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      write_q      <= write_d;
      wd_q         <= wd_d;
      hit_cnt_q    <= hit_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
      line_addr_q  <= line_addr_d;
      line_val_q   <= line_val_d;
      line_read_q  <= line_read_d;
      line_write_q <= line_write_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      resp_data_q  <= resp_data_d;
      resp_hit_q   <= resp_hit_d;
      resp_err_q   <= resp_err_d;
    end
  end

  // req_ready is held low while reset is asserted so every output reads 0.
  assign req_ready  = reset_n && (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_data  = resp_data_q;
  assign resp_hit   = resp_hit_q;
  assign resp_err   = resp_err_q;
  assign line_addr  = line_addr_q;
  assign line_val   = line_val_q;
  assign line_read  = line_read_q;
  assign line_write = line_write_q;
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;

endmodule

// File: tb/tb_cache_ctrl.sv
module tb_cache_ctrl;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0, req_ready, req_write = 1'b0;
  logic [7:0]  req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid, resp_ready = 1'b1;
  logic [31:0] resp_data;
  logic        resp_hit, resp_err;
  logic [7:0]  line_addr;
  logic [31:0] line_val;
  logic        line_read, line_write;
  logic        line_hit = 1'b0;
  logic [31:0] line_out_val = '0;
  logic        mem_req, mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic [1:0]  hit_count, miss_count;

  always #5 clock = ~clock;

  cache_ctrl #(.MEM_TIMEOUT(4), .CNT_W(2)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_hit(resp_hit), .resp_err(resp_err),
    .line_addr(line_addr), .line_val(line_val), .line_read(line_read),
    .line_write(line_write), .line_hit(line_hit), .line_out_val(line_out_val),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  typedef struct {
    logic [31:0] data;
    logic        hit;
    logic        err;
  } resp_t;

  resp_t exp_q[$];
  resp_t sb_e;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  // Environment models
  logic        line_hit_mode = 1'b0;
  logic [31:0] line_data = '0;
  logic        prev_rd = 1'b0;
  int          mem_lat = 1;
  logic [31:0] mem_data = '0;
  logic        mem_never = 1'b0;
  int          mem_cnt = 0;

  // Line answers in the cycle after the probe strobe, and only then.
  always @(negedge clock) begin
    line_hit     = prev_rd ? line_hit_mode : 1'b0;
    line_out_val = prev_rd ? line_data : 32'h0;
    prev_rd      = line_read;
  end

  // Memory acks in the mem_lat-th cycle of a held request.
  always @(negedge clock) begin
    if (mem_req && !mem_never) begin
      mem_cnt++;
      mem_ack   = (mem_cnt == mem_lat);
      mem_rdata = (mem_cnt == mem_lat) ? mem_data : 32'h0;
    end else begin
      mem_cnt   = 0;
      mem_ack   = 1'b0;
      mem_rdata = 32'h0;
    end
  end

  // Monitors
  logic        exp_we = 1'b0;
  logic [7:0]  exp_addr = '0;
  logic [31:0] exp_wdata = '0;
  int          memreq_cycles = 0;
  int          lw_cnt = 0;
  int          lr_cnt = 0;
  logic [7:0]  lw_addr = '0;
  logic [31:0] lw_val = '0;

  always @(negedge clock) begin
    if (reset_n && resp_valid && resp_ready) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_resp", 32'd1, 32'd0);
      end else begin
        sb_e = exp_q.pop_front();
        check("sb_resp_data", resp_data, sb_e.data);
        check("sb_resp_hit", {31'b0, resp_hit}, {31'b0, sb_e.hit});
        check("sb_resp_err", {31'b0, resp_err}, {31'b0, sb_e.err});
      end
    end
  end

  always @(negedge clock) begin
    if (mem_req) begin
      memreq_cycles++;
      check("mem_we_held", {31'b0, mem_we}, {31'b0, exp_we});
      check("mem_addr_held", {24'b0, mem_addr}, {24'b0, exp_addr});
      if (exp_we) check("mem_wdata_held", mem_wdata, exp_wdata);
    end
    if (line_write) begin
      lw_cnt++;
      lw_addr = line_addr;
      lw_val  = line_val;
    end
    if (line_read) lr_cnt++;
  end

  task automatic push(input logic [31:0] d, input logic h, input logic e);
    resp_t r;
    r.data = d; r.hit = h; r.err = e;
    exp_q.push_back(r);
  endtask

  task automatic issue(input logic w, input logic [7:0] a, input logic [31:0] d);
    int n;
    n = 0;
    @(negedge clock);
    while (!req_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (!req_ready) check("req_ready_wait", 32'd0, 32'd1);
    exp_we = w; exp_addr = a; exp_wdata = d;
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    @(posedge clock);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_resp(output int edges);
    edges = 0;
    while (!resp_valid && edges < 40) begin
      @(posedge clock);
      #1;
      edges++;
    end
    if (!resp_valid) check("resp_wait_bound", 32'd0, 32'd1);
  endtask

  task automatic finish_resp();
    @(posedge clock);
    #1;
  endtask

  int ed, lw0, mr0, lr0, n;

  initial begin
    // Reset state
    repeat (2) @(negedge clock);
    check("rst_mem_req", {31'b0, mem_req}, 32'd0);
    check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("rst_req_ready", {31'b0, req_ready}, 32'd0);
    check("rst_line_write", {31'b0, line_write}, 32'd0);
    check("rst_hit_count", {30'b0, hit_count}, 32'd0);
    check("rst_miss_count", {30'b0, miss_count}, 32'd0);
    reset_n = 1'b1;
    @(negedge clock);
    check("post_rst_req_ready", {31'b0, req_ready}, 32'd1);

    // Cold read miss, ack in 3rd mem cycle
    line_hit_mode = 1'b0; mem_lat = 3; mem_data = 32'hDEADBEEF;
    lw0 = lw_cnt; mr0 = memreq_cycles;
    push(32'hDEADBEEF, 1'b0, 1'b0);
    issue(1'b0, 8'h12, 32'h0);
    wait_resp(ed);
    check("cold_latency", ed, 32'd6);
    check("cold_line_writes", lw_cnt - lw0, 32'd1);
    check("cold_line_addr", {24'b0, lw_addr}, 32'h12);
    check("cold_line_val", lw_val, 32'hDEADBEEF);
    check("cold_mem_cycles", memreq_cycles - mr0, 32'd3);
    finish_resp();
    check("cold_miss_count", {30'b0, miss_count}, 32'd1);
    check("cold_hit_count", {30'b0, hit_count}, 32'd0);

    // Read hit
    line_hit_mode = 1'b1; line_data = 32'hDEADBEEF;
    lw0 = lw_cnt; mr0 = memreq_cycles;
    push(32'hDEADBEEF, 1'b1, 1'b0);
    issue(1'b0, 8'h12, 32'h0);
    wait_resp(ed);
    check("hit_latency", ed, 32'd2);
    check("hit_no_mem_req", memreq_cycles - mr0, 32'd0);
    check("hit_no_line_write", lw_cnt - lw0, 32'd0);
    finish_resp();
    check("hit_hit_count", {30'b0, hit_count}, 32'd1);
    check("hit_miss_count", {30'b0, miss_count}, 32'd1);

    // Write-through
    mem_lat = 3;
    lw0 = lw_cnt; mr0 = memreq_cycles; lr0 = lr_cnt;
    push(32'h0, 1'b0, 1'b0);
    issue(1'b1, 8'h34, 32'hCAFEF00D);
    wait_resp(ed);
    check("wr_latency", ed, 32'd4);
    check("wr_mem_cycles", memreq_cycles - mr0, 32'd3);
    check("wr_no_lookup", lr_cnt - lr0, 32'd0);
    check("wr_line_writes", lw_cnt - lw0, 32'd1);
    check("wr_line_addr", {24'b0, lw_addr}, 32'h34);
    check("wr_line_val", lw_val, 32'hCAFEF00D);
    finish_resp();
    check("wr_hit_count", {30'b0, hit_count}, 32'd1);
    check("wr_miss_count", {30'b0, miss_count}, 32'd1);

    // Timeout: ack never arrives
    line_hit_mode = 1'b0; mem_never = 1'b1;
    lw0 = lw_cnt; mr0 = memreq_cycles;
    push(32'h0, 1'b0, 1'b1);
    issue(1'b0, 8'h56, 32'h0);
    wait_resp(ed);
    check("to_latency", ed, 32'd6);
    check("to_mem_cycles", memreq_cycles - mr0, 32'd4);
    check("to_no_line_write", lw_cnt - lw0, 32'd0);
    finish_resp();
    check("to_miss_count", {30'b0, miss_count}, 32'd2);

    // Ack on the expiry cycle, response stalled 5 cycles
    mem_never = 1'b0; mem_lat = 4; mem_data = 32'h12345678;
    lw0 = lw_cnt; mr0 = memreq_cycles;
    resp_ready = 1'b0;
    push(32'h12345678, 1'b0, 1'b0);
    issue(1'b0, 8'h78, 32'h0);
    wait_resp(ed);
    check("race_latency", ed, 32'd7);
    check("race_mem_cycles", memreq_cycles - mr0, 32'd4);
    check("race_line_writes", lw_cnt - lw0, 32'd1);
    check("race_line_addr", {24'b0, lw_addr}, 32'h78);
    check("race_line_val", lw_val, 32'h12345678);
    for (int i = 0; i < 5; i++) begin
      @(posedge clock);
      #1;
      check("stall_resp_valid", {31'b0, resp_valid}, 32'd1);
      check("stall_resp_data", resp_data, 32'h12345678);
      check("stall_resp_err", {31'b0, resp_err}, 32'd0);
      check("stall_req_ready", {31'b0, req_ready}, 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clock);
    #1;
    check("race_req_ready_after_hs", {31'b0, req_ready}, 32'd1);
    check("race_miss_count", {30'b0, miss_count}, 32'd3);

    // Miss counter saturation
    mem_lat = 1; mem_data = 32'h0BADF00D;
    push(32'h0BADF00D, 1'b0, 1'b0);
    issue(1'b0, 8'h9A, 32'h0);
    wait_resp(ed);
    check("sat_latency", ed, 32'd4);
    finish_resp();
    check("sat_miss_count", {30'b0, miss_count}, 32'd3);

    // Reset during MEM_RD
    mem_never = 1'b1;
    issue(1'b0, 8'h55, 32'h0);
    n = 0;
    while (!mem_req && n < 20) begin
      @(negedge clock);
      n++;
    end
    check("mid_mem_req_seen", {31'b0, mem_req}, 32'd1);
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    check("mid_mem_req_drop", {31'b0, mem_req}, 32'd0);
    check("mid_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("mid_hit_count", {30'b0, hit_count}, 32'd0);
    check("mid_miss_count", {30'b0, miss_count}, 32'd0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    mem_never = 1'b0;
    @(negedge clock);
    check("mid_req_ready", {31'b0, req_ready}, 32'd1);

    // Clean restart, then hit counter saturation
    line_hit_mode = 1'b1; line_data = 32'h11112222;
    for (int i = 0; i < 4; i++) begin
      push(32'h11112222, 1'b1, 1'b0);
      issue(1'b0, 8'h12, 32'h0);
      wait_resp(ed);
      check("clean_hit_latency", ed, 32'd2);
      finish_resp();
      if (i == 0) check("clean_hit_count", {30'b0, hit_count}, 32'd1);
    end
    check("sat_hit_count", {30'b0, hit_count}, 32'd3);
    check("final_miss_count", {30'b0, miss_count}, 32'd0);

    repeat (2) @(negedge clock);
    check("sb_drained", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
